// File: rtl/mem_bist_ctrl.sv
// Memory built-in self-test master for the single-port mem block.
// Each run writes a linear pattern to NUM_WORDS words, reads them back and compares.
// Pass/fail, a saturating error count and the first failing address are reported.
// A request left waiting for ready for TIMEOUT cycles aborts the run.
module mem_bist_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned PAT_MULT   = 10,
  parameter int unsigned PAT_SEED   = 0,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready
);

  // Timer only has to reach TIMEOUT-1 before the abort fires.
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmrW-1:0]       TmrLast = TmrW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrGap, StRdReq, StRdGap, StDone
  } state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [TmrW-1:0]       timer;

  // Address wraps naturally in ADDR_WIDTH bits.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] i);
    return ADDR_WIDTH'(BASE_ADDR) + i;
  endfunction

  // Pattern arithmetic is done modulo 2**WIDTH.
  function automatic logic [WIDTH-1:0] pat_of(input logic [ADDR_WIDTH-1:0] i);
    return WIDTH'(i) * WIDTH'(PAT_MULT) + WIDTH'(PAT_SEED);
  endfunction

  // Sequencer: all status and memory request outputs are registered here.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state          <= StIdle;
      idx            <= '0;
      timer          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      mem_valid      <= 1'b0;
      mem_wr_rd      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            idx            <= '0;
            timer          <= '0;
            busy           <= 1'b1;
            mem_valid      <= 1'b1;
            mem_wr_rd      <= 1'b1;
            mem_addr       <= addr_of('0);
            mem_wdata      <= pat_of('0);
            state          <= StWrReq;
          end
        end
        StWrReq, StRdReq: begin
          if (mem_ready) begin
            if (state == StRdReq && mem_rdata != pat_of(idx)) begin
              if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
              if (err_count == '0) first_err_addr <= mem_addr;
            end
            mem_valid <= 1'b0;
            state     <= (state == StWrReq) ? StWrGap : StRdGap;
          end else if (timer == TmrLast) begin
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            state     <= StDone;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StWrGap: begin
          mem_valid <= 1'b1;
          timer     <= '0;
          if (idx == LastIdx) begin
            idx       <= '0;
            mem_wr_rd <= 1'b0;
            mem_addr  <= addr_of('0);
            mem_wdata <= pat_of('0);
            state     <= StRdReq;
          end else begin
            idx       <= idx + 1'b1;
            mem_addr  <= addr_of(idx + 1'b1);
            mem_wdata <= pat_of(idx + 1'b1);
            state     <= StWrReq;
          end
        end
        StRdGap: begin
          if (idx == LastIdx) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
            state <= StDone;
          end else begin
            idx       <= idx + 1'b1;
            timer     <= '0;
            mem_valid <= 1'b1;
            mem_addr  <= addr_of(idx + 1'b1);
            mem_wdata <= pat_of(idx + 1'b1);
            state     <= StRdReq;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (default and wrapped/saturating config),
// each driven by a behavioural memory with random ready delay, corruption and hang knobs.
module tb_mem_bist_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        res;
  logic        start      [2];
  logic        busy       [2];
  logic        done       [2];
  logic        pass       [2];
  logic        tmo        [2];
  logic        mem_valid  [2];
  logic        mem_wr_rd  [2];
  logic        mem_ready  [2];
  logic [7:0]  fea        [2];
  logic [7:0]  mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic [15:0] mem_rdata  [2];
  logic [7:0]  ec0;
  logic [1:0]  ec1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bist_ctrl dut0 (
    .clk(clk), .res(res), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .timeout(tmo[0]), .err_count(ec0), .first_err_addr(fea[0]),
    .mem_valid(mem_valid[0]), .mem_wr_rd(mem_wr_rd[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0])
  );

  mem_bist_ctrl #(
    .BASE_ADDR(250), .PAT_MULT(40000), .PAT_SEED(7), .TIMEOUT(8), .CNT_W(2)
  ) dut1 (
    .clk(clk), .res(res), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .timeout(tmo[1]), .err_count(ec1), .first_err_addr(fea[1]),
    .mem_valid(mem_valid[1]), .mem_wr_rd(mem_wr_rd[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference configuration of each instance.
  function automatic int base_of(input int k);
    return (k != 0) ? 250 : 0;
  endfunction

  function automatic logic [15:0] pat(input int k, input int unsigned i);
    int unsigned m;
    int unsigned s;
    m = (k != 0) ? 40000 : 10;
    s = (k != 0) ? 7 : 0;
    return 16'((i * m + s) % 32'd65536);
  endfunction

  function automatic int errc(input int k);
    return (k != 0) ? int'(ec1) : int'(ec0);
  endfunction

  // Behavioural memory model state.
  logic [15:0] mem_arr [2][256];
  bit          corrupt [2][256];
  int          hang    [2];
  int          dly     [2];
  int          wcnt    [2];
  int          dmax    [2];
  int          n_hs    [2];
  int          vlen    [2];
  int          last_vlen [2];
  bit          prev_hs [2];

  // Memory model: decides ready for the coming posedge and checks each accepted transaction.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] a;
      int         i;
      a = mem_addr[k];
      if (prev_hs[k]) check("gap", 64'(mem_valid[k]), 64'd0);
      prev_hs[k] = 1'b0;
      if (mem_valid[k]) begin
        vlen[k]++;
        if (hang[k] == int'(a) && mem_wr_rd[k]) begin
          mem_ready[k] = 1'b0;
        end else if (wcnt[k] < dly[k]) begin
          mem_ready[k] = 1'b0;
          wcnt[k]++;
        end else begin
          mem_ready[k] = 1'b1;
          prev_hs[k]   = 1'b1;
          wcnt[k]      = 0;
          dly[k]       = $urandom_range(dmax[k], 0);
          i            = n_hs[k];
          if (i < N) begin
            check("wr_txn", 64'({mem_wr_rd[k], a, mem_wdata[k]}),
                  64'({1'b1, 8'(base_of(k) + i), pat(k, i)}));
          end else begin
            check("rd_txn", 64'({mem_wr_rd[k], a}), 64'({1'b0, 8'(base_of(k) + i - N)}));
          end
          if (mem_wr_rd[k]) mem_arr[k][a] = mem_wdata[k];
          else mem_rdata[k] = mem_arr[k][a] ^ (corrupt[k][a] ? 16'h0101 : 16'h0000);
          n_hs[k]++;
        end
      end else begin
        if (vlen[k] != 0) last_vlen[k] = vlen[k];
        vlen[k]      = 0;
        mem_ready[k] = 1'($urandom_range(1, 0));
        mem_rdata[k] = 16'($urandom);
      end
    end
  end

  task automatic check_reset(input int k, input string tag);
    check(tag, 64'({busy[k], done[k], pass[k], tmo[k], mem_valid[k], mem_wr_rd[k],
                    8'(errc(k)), fea[k], mem_addr[k], mem_wdata[k]}), 64'd0);
  endtask

  task automatic clear_corrupt();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) corrupt[k][a] = 1'b0;
  endtask

  // One complete run with expectations derived from the corruption/hang setup.
  task automatic do_run(input int k, input int maxd, input int hang_a, input bit poke);
    int ne;
    int first;
    int cmax;
    int s;
    int hidx;
    bit got;
    dmax[k] = maxd;
    hang[k] = hang_a;
    n_hs[k] = 0;
    wcnt[k] = 0;
    dly[k]  = $urandom_range(maxd, 0);
    ne      = 0;
    first   = 0;
    cmax    = (k != 0) ? 3 : 255;
    for (int i = 0; i < N; i++) begin
      int a;
      a = (base_of(k) + i) % 256;
      if (corrupt[k][a]) begin
        if (ne == 0) first = a;
        ne++;
      end
    end
    if (ne > cmax) ne = cmax;
    @(negedge clk);
    start[k] = 1'b1;
    s = cyc;
    @(negedge clk);
    start[k] = 1'b0;
    #1;
    check("accepted", 64'({busy[k], done[k], pass[k], tmo[k]}), 64'b1000);
    check("cleared", 64'({8'(errc(k)), fea[k]}), 64'd0);
    got = 1'b0;
    for (int t = 0; t < 5000 && !got; t++) begin
      start[k] = poke && (t == 7);
      @(negedge clk);
      #1;
      got = done[k];
    end
    start[k] = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    check("busy_end", 64'(busy[k]), 64'd0);
    check("valid_end", 64'(mem_valid[k]), 64'd0);
    if (hang_a >= 0) begin
      hidx = (hang_a - base_of(k) + 256) % 256;
      check("tmo_flags", 64'({tmo[k], pass[k]}), 64'b10);
      check("tmo_len", 64'(last_vlen[k]), 64'((k != 0) ? 8 : 64));
      check("tmo_txns", 64'(n_hs[k]), 64'(hidx));
      check("tmo_err", 64'(errc(k)), 64'd0);
    end else begin
      check("pass", 64'({tmo[k], pass[k]}), 64'({1'b0, ne == 0}));
      check("err_count", 64'(errc(k)), 64'(ne));
      check("first_err", 64'(fea[k]), 64'(first));
      check("txns", 64'(n_hs[k]), 64'(2 * N));
      if (maxd == 0) check("run_len", 64'(cyc - (s + 1)), 64'(4 * N));
    end
  endtask

  initial begin
    res = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k]     = 1'b0;
      mem_ready[k] = 1'b0;
      mem_rdata[k] = '0;
      hang[k]      = -1;
      dly[k]       = 0;
      wcnt[k]      = 0;
      dmax[k]      = 0;
      n_hs[k]      = 0;
      vlen[k]      = 0;
      last_vlen[k] = 0;
      prev_hs[k]   = 1'b0;
    end
    clear_corrupt();
    #12;
    check_reset(0, "reset0");
    check_reset(1, "reset1");
    @(negedge clk);
    res = 1'b1;

    // Clean run, single-cycle ready.
    do_run(0, 0, -1, 1'b0);
    // Corrupted reads at 5 and 9.
    corrupt[0][5] = 1'b1;
    corrupt[0][9] = 1'b1;
    do_run(0, 2, -1, 1'b0);
    clear_corrupt();
    // Write to addr 3 never completes.
    do_run(0, 0, 3, 1'b0);
    // Wrapping base address, clean.
    do_run(1, 0, -1, 1'b0);
    // Start pulsed while busy, started from DONE.
    do_run(0, 0, -1, 1'b1);
    do_run(1, 0, -1, 1'b1);
    // Hang on the wrapped instance (addr 1 is index 7).
    do_run(1, 1, 1, 1'b0);

    // Random corruption and ready delays on both instances.
    for (int r = 0; r < 8; r++) begin
      int k;
      k = r % 2;
      for (int a = 0; a < 256; a++) corrupt[k][a] = ($urandom_range(3, 0) == 0);
      do_run(k, $urandom_range(4, 0), -1, 1'b0);
      clear_corrupt();
    end

    // Reset in the middle of the read phase, then a clean run.
    hang[0] = -1;
    dmax[0] = 2;
    n_hs[0] = 0;
    wcnt[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int t = 0; t < 2000 && n_hs[0] < N + 4; t++) @(negedge clk);
    check("rd_phase", 64'(n_hs[0] >= N + 4), 64'd1);
    #2 res = 1'b0;
    #1 check_reset(0, "mid_reset");
    @(negedge clk);
    #1 check_reset(0, "held_reset");
    res = 1'b1;
    do_run(0, 1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
